// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer and fetch controller for the MIPS IF stage.
// Owns the PC, drives the synchronous instruction memory's address and enable,
// and produces the valid/flush qualifiers consumed by the IF/ID register.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN   00 | fetching one instruction per cycle
// STALL 01 | ID requested a hold; pc, id_pc and if_valid are frozen
// HALT  10 | fetch stopped; only a redirect (pc load) or resume acts
module fetch_ctrl #(
  parameter int              PC_W     = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jmp_en,
  input  logic [PC_W-1:0]   jmp_address,
  input  logic              br_en,
  input  logic [PC_W-1:0]   br_offset,
  input  logic              halt_req,
  input  logic              resume,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   PCnext,
  output logic              imem_en,
  output logic              if_valid,
  output logic              flush,
  output logic [PC_W-1:0]   id_pc,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  fetch_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, id_pc_q;
  logic               if_valid_q, flush_q;
  logic [CNT_W-1:0]   fetch_cnt_q;

  logic               redirect;
  logic               seq_fetch;
  logic [PC_W-1:0]    target;

  // Jump beats branch. Modular add at PC_W bits gives the sign-extended
  // offset behaviour for free, including wrap past the top of memory.
  assign redirect = jmp_en | br_en;
  assign target   = jmp_en ? jmp_address : (id_pc_q + PC_W'(1) + br_offset);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next-state: redirect > halt_req > stall > sequential; HALT only leaves on resume
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (!redirect && resume && !halt_req) state_d = ST_RUN;
      end
      default: begin
        if (redirect)      state_d = ST_RUN;
        else if (halt_req) state_d = ST_HALT;
        else if (stall)    state_d = ST_STALL;
        else               state_d = ST_RUN;
      end
    endcase
  end

  // Outputs: memory enable and the "a fetch is committed this edge" strobe
  always_comb begin
    imem_en   = (state_q != ST_HALT) && !stall && !redirect;
    seq_fetch = imem_en && !halt_req;
  end

  // PC, IF/ID qualifiers and fetch counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      id_pc_q     <= '0;
      if_valid_q  <= 1'b0;
      flush_q     <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      flush_q <= redirect;
      if (redirect) begin
        pc_q       <= target;
        if_valid_q <= 1'b0;
      end else if (seq_fetch) begin
        id_pc_q     <= pc_q;
        pc_q        <= pc_q + PC_W'(1);
        if_valid_q  <= 1'b1;
        fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
      end else if (state_d == ST_HALT) begin
        if_valid_q <= 1'b0;
      end
    end
  end

  assign pc        = pc_q;
  assign PCnext    = id_pc_q + PC_W'(1);
  assign if_valid  = if_valid_q;
  assign flush     = flush_q;
  assign id_pc     = id_pc_q;
  assign state     = state_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed walk through the fetch scenarios, then
// randomized traffic, all compared against a behavioural model of the fetch rules.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jmp_en;
  logic [5:0]  jmp_address;
  logic        br_en;
  logic [5:0]  br_offset;
  logic        halt_req;
  logic        resume;
  logic [5:0]  pc;
  logic [5:0]  PCnext;
  logic        imem_en;
  logic        if_valid;
  logic        flush;
  logic [5:0]  id_pc;
  logic [1:0]  state;
  logic [15:0] fetch_cnt;

  fetch_ctrl #(.PC_W(6), .RESET_PC(6'd0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jmp_en(jmp_en),
    .jmp_address(jmp_address), .br_en(br_en), .br_offset(br_offset),
    .halt_req(halt_req), .resume(resume), .pc(pc), .PCnext(PCnext),
    .imem_en(imem_en), .if_valid(if_valid), .flush(flush), .id_pc(id_pc),
    .state(state), .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Behavioural model
  logic [5:0] m_pc, m_id;
  logic       m_v, m_fl;
  logic [1:0] m_st;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 6'd0; m_id = 6'd0; m_v = 1'b0; m_fl = 1'b0; m_st = 2'd0; m_cnt = 0;
  endtask

  function automatic logic m_imem();
    return (m_st != 2'd2) && !stall && !(jmp_en || br_en);
  endfunction

  function automatic logic [5:0] m_pcnext();
    return 6'((int'(m_id) + 1) % 64);
  endfunction

  task automatic model_update();
    int tgt;
    int off;
    logic redir;
    if (rst) begin
      model_reset();
    end else begin
      redir = jmp_en || br_en;
      if (jmp_en) begin
        tgt = int'(jmp_address);
      end else begin
        off = int'(br_offset);
        if (off >= 32) off = off - 64;
        tgt = (int'(m_id) + 1 + off + 128) % 64;
      end
      m_fl = redir;
      if (m_st == 2'd2) begin
        if (redir) m_pc = 6'(tgt);
        else if (resume && !halt_req) m_st = 2'd0;
        m_v = 1'b0;
      end else if (redir) begin
        m_pc = 6'(tgt); m_v = 1'b0; m_st = 2'd0;
      end else if (halt_req) begin
        m_st = 2'd2; m_v = 1'b0;
      end else if (stall) begin
        m_st = 2'd1;
      end else begin
        m_id  = m_pc;
        m_pc  = 6'((int'(m_pc) + 1) % 64);
        m_v   = 1'b1;
        m_cnt = (m_cnt + 1) % 65536;
        m_st  = 2'd0;
      end
    end
  endtask

  task automatic check_regs();
    chk("pc", pc, m_pc);
    chk("id_pc", id_pc, m_id);
    chk("if_valid", if_valid, m_v);
    chk("flush", flush, m_fl);
    chk("state", state, m_st);
    chk("fetch_cnt", fetch_cnt, 16'(m_cnt));
  endtask

  // Inputs are already driven; check combinational outputs, clock, check registers.
  task automatic step();
    #3;
    chk("imem_en", imem_en, m_imem());
    chk("PCnext", PCnext, m_pcnext());
    @(posedge clk);
    model_update();
    #1;
    check_regs();
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; jmp_en = 1'b0; jmp_address = 6'd0;
    br_en = 1'b0; br_offset = 6'd0; halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic jump_to(input logic [5:0] a);
    idle_inputs(); jmp_en = 1'b1; jmp_address = a; step(); idle_inputs();
  endtask

  logic [15:0] cnt_save;

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_regs();
    chk("reset_pc", pc, 6'd0);
    chk("reset_state", state, 2'd0);

    // Free-running fetch from reset
    rst = 1'b0;
    repeat (4) step();
    chk("run_pc4", pc, 6'd4);
    chk("run_id3", id_pc, 6'd3);
    chk("run_cnt4", fetch_cnt, 16'd4);
    step();

    // Jump at pc=5
    chk("pre_jump_pc", pc, 6'd5);
    jump_to(6'd40);
    chk("jump_pc", pc, 6'd40);
    chk("jump_flush", flush, 1'b1);
    chk("jump_bubble", if_valid, 1'b0);
    step();
    chk("jump_id", id_pc, 6'd40);
    chk("jump_valid", if_valid, 1'b1);
    chk("jump_flush_off", flush, 1'b0);

    // Branch at id_pc=10, then jump+branch together
    jump_to(6'd10);
    step();
    chk("pre_br_id", id_pc, 6'd10);
    br_en = 1'b1; br_offset = 6'h3E; step();
    chk("branch_back", pc, 6'd9);
    jmp_en = 1'b1; jmp_address = 6'd20; step();
    chk("jump_priority", pc, 6'd20);
    idle_inputs();

    // Stall at pc=7
    jump_to(6'd6);
    step();
    chk("pre_stall_pc", pc, 6'd7);
    cnt_save = fetch_cnt;
    stall = 1'b1;
    #1 chk("stall_imem_comb", imem_en, 1'b0);
    repeat (3) step();
    chk("stall_pc", pc, 6'd7);
    chk("stall_id", id_pc, 6'd6);
    chk("stall_valid", if_valid, 1'b1);
    chk("stall_state", state, 2'd1);
    chk("stall_cnt", fetch_cnt, cnt_save);
    stall = 1'b0; step();
    chk("release_pc", pc, 6'd8);
    stall = 1'b1; step();
    jmp_en = 1'b1; jmp_address = 6'd30; step();
    chk("stall_redirect_pc", pc, 6'd30);
    chk("stall_redirect_state", state, 2'd0);
    idle_inputs();

    // Wrap of pc and of branch target
    jump_to(6'd62);
    step();
    step();
    chk("pc_wrap", pc, 6'd0);
    jump_to(6'd62);
    step();
    br_en = 1'b1; br_offset = 6'd3; step();
    chk("branch_wrap", pc, 6'd2);
    idle_inputs();

    // Halt at pc=12
    jump_to(6'd12);
    halt_req = 1'b1; step();
    halt_req = 1'b0;
    chk("halt_state", state, 2'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_pc_hold", pc, 6'd12);
      chk("halt_valid", if_valid, 1'b0);
    end
    halt_req = 1'b1; resume = 1'b1; step();
    chk("halt_and_resume", state, 2'd2);
    halt_req = 1'b0; resume = 1'b0;
    jmp_en = 1'b1; jmp_address = 6'd12; step();
    chk("halt_redirect_state", state, 2'd2);
    chk("halt_redirect_flush", flush, 1'b1);
    idle_inputs();
    resume = 1'b1; step();
    resume = 1'b0;
    chk("resume_state", state, 2'd0);
    chk("resume_pc", pc, 6'd12);
    step();
    chk("resume_fetch_id", id_pc, 6'd12);
    chk("resume_fetch_pc", pc, 6'd13);
    halt_req = 1'b1; step();
    halt_req = 1'b0; rst = 1'b1; step();
    chk("halt_reset_pc", pc, 6'd0);
    chk("halt_reset_state", state, 2'd0);
    idle_inputs();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 59) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      jmp_en      = ($urandom_range(0, 9) == 0);
      br_en       = ($urandom_range(0, 9) == 0);
      jmp_address = 6'($urandom);
      br_offset   = 6'($urandom);
      halt_req    = ($urandom_range(0, 19) == 0);
      resume      = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
